// File: rtl/uart_rx_deserializer.sv
// UART receive core: synchronizes rx_i, finds start bits and samples each bit at
// mid-period with a fractional baud accumulator, delivering one byte per frame.
module uart_rx_deserializer #(
  parameter int CLK_FREQ = 10_000_000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rx_i,
  input  logic [16:0] baudrate_i,
  input  logic        parity_en_i,
  input  logic        stopbit_i,
  output logic        busy_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  output logic        rx_err_o
);

  localparam int ACC_W = $clog2(2 * CLK_FREQ);
  localparam int SUM_W = (ACC_W > 17) ? ACC_W + 1 : 18;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [2:0]       state;
  logic             sync1, sync2, sync_prev;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [SUM_W-1:0] acc_sum;
  logic             tick;
  logic [16:0]      baud_q;
  logic             parity_en_q;
  logic             stop2_q;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             parity_err;
  logic             frame_err;
  logic             fall;

  assign fall   = sync_prev & ~sync2;
  assign busy_o = (state != ST_IDLE);

  // Accumulator wraps modulo CLK_FREQ; each wrap is one bit period on average.
  always_comb begin
    acc_sum  = SUM_W'(acc) + SUM_W'(baud_q);
    tick     = (acc_sum >= SUM_W'(CLK_FREQ));
    acc_next = tick ? ACC_W'(acc_sum - SUM_W'(CLK_FREQ)) : ACC_W'(acc_sum);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      sync_prev   <= 1'b1;
      state       <= ST_IDLE;
      acc         <= '0;
      baud_q      <= '0;
      parity_en_q <= 1'b0;
      stop2_q     <= 1'b0;
      bit_cnt     <= '0;
      shreg       <= '0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      rx_data_o   <= '0;
      rx_valid_o  <= 1'b0;
      rx_err_o    <= 1'b0;
    end else begin
      sync1      <= rx_i;
      sync2      <= sync1;
      sync_prev  <= sync2;
      rx_valid_o <= 1'b0;
      rx_err_o   <= 1'b0;

      if (state != ST_IDLE) begin
        acc <= acc_next;
      end

      case (state)
        ST_IDLE: begin
          // Starting at half the modulus puts the first tick mid-start-bit.
          if (fall && (baudrate_i != 17'd0)) begin
            baud_q      <= baudrate_i;
            parity_en_q <= parity_en_i;
            stop2_q     <= stopbit_i;
            acc         <= ACC_W'(CLK_FREQ / 2);
            state       <= ST_START;
          end
        end

        ST_START: begin
          if (tick) begin
            if (!sync2) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end

        ST_DATA: begin
          if (tick) begin
            shreg   <= {sync2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              state   <= parity_en_q ? ST_PARITY : ST_STOP;
            end
          end
        end

        ST_PARITY: begin
          if (tick) begin
            if (^{sync2, shreg}) begin
              parity_err <= 1'b1;
            end
            state <= ST_STOP;
          end
        end

        ST_STOP: begin
          // The current sample is folded in directly since the flag update would land too late.
          if (tick) begin
            if (stop2_q && (bit_cnt == 3'd0)) begin
              bit_cnt <= 3'd1;
              if (!sync2) begin
                frame_err <= 1'b1;
              end
            end else begin
              state      <= ST_IDLE;
              bit_cnt    <= '0;
              rx_data_o  <= shreg;
              parity_err <= 1'b0;
              frame_err  <= 1'b0;
              if (parity_err || frame_err || !sync2) begin
                rx_err_o <= 1'b1;
              end else begin
                rx_valid_o <= 1'b1;
              end
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Randomized self-checking bench for uart_rx_deserializer; frame outcomes are
// predicted from the frame bits alone and compared with the observed pulses.
module tb_uart_rx_deserializer;

  localparam int CLK_FREQ = 1_000_000;

  logic        clk;
  logic        rst_n;
  logic        rx;
  logic [16:0] baudrate;
  logic        parity_en;
  logic        stopbit;
  logic        busy;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_err;

  int          check_cnt;
  int          pass_cnt;
  longint      cyc;
  int          valid_cnt;
  int          err_cnt;
  int          busy_cycles;
  int          viol_cnt;
  logic [7:0]  prev_data;
  logic [7:0]  pulse_data[$];
  longint      pulse_time[$];

  uart_rx_deserializer #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rx_i       (rx),
    .baudrate_i (baudrate),
    .parity_en_i(parity_en),
    .stopbit_i  (stopbit),
    .busy_o     (busy),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .rx_err_o   (rx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs mid-cycle: count pulses, busy time and unexpected data changes.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_data = rx_data;
    end else begin
      if (busy) busy_cycles++;
      if (rx_valid) valid_cnt++;
      if (rx_err) err_cnt++;
      if (rx_valid && rx_err) viol_cnt++;
      if (rx_valid || rx_err) begin
        pulse_data.push_back(rx_data);
        pulse_time.push_back(cyc);
      end else if (rx_data !== prev_data) begin
        viol_cnt++;
      end
      prev_data = rx_data;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    check_cnt++;
    if (observed === expected) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one whole frame with drift-free bit boundaries; optionally disturbs
  // the configuration inputs after the start bit to exercise the latch.
  task automatic apply_stimulus(input logic [7:0] data, input bit par_en,
                                input bit par_bit, input bit two_stop,
                                input bit stop1, input bit stop2,
                                input int baud, input bit scramble);
    logic   bits[$];
    longint t0;
    longint target;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    if (par_en) bits.push_back(par_bit);
    bits.push_back(stop1);
    if (two_stop) bits.push_back(stop2);
    baudrate  = 17'(baud);
    parity_en = par_en;
    stopbit   = two_stop;
    t0 = cyc;
    for (int k = 0; k < bits.size(); k++) begin
      rx = bits[k];
      if (scramble && k == 1) begin
        baudrate  = 17'd40000;
        parity_en = ~par_en;
        stopbit   = ~two_stop;
      end
      target = t0 + ((longint'(k) + 1) * CLK_FREQ) / baud;
      while (cyc < target) begin
        @(posedge clk);
        #1;
      end
    end
    rx = 1'b1;
  endtask

  int          v0, e0, b0;
  logic [7:0]  d0;
  logic [7:0]  r_data;
  bit          r_par, r_pbit, r_two, r_s1, r_s2, r_err;
  int          r_baud, r_sel, r_gap;
  int          baud_set[4] = '{100000, 125000, 62500, 30000};

  initial begin
    check_cnt   = 0;
    pass_cnt    = 0;
    cyc         = 0;
    valid_cnt   = 0;
    err_cnt     = 0;
    busy_cycles = 0;
    viol_cnt    = 0;
    rst_n       = 1'b0;
    rx          = 1'b1;
    baudrate    = 17'd100000;
    parity_en   = 1'b0;
    stopbit     = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    check_output("rst_busy", busy, 0);
    check_output("rst_data", rx_data, 0);
    check_output("rst_valid", rx_valid, 0);
    check_output("rst_err", rx_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // Clean frame with even parity bit 0.
    v0 = valid_cnt; e0 = err_cnt; busy_cycles = 0;
    apply_stimulus(8'hA5, 1, 0, 0, 1, 1, 100000, 0);
    repeat (5) @(posedge clk); #1;
    check_output("clean_valid", valid_cnt - v0, 1);
    check_output("clean_err", err_cnt - e0, 0);
    check_output("clean_data", rx_data, 8'hA5);
    check_output("clean_busy_len", (busy_cycles >= 100 && busy_cycles <= 110), 1);

    // Parity error.
    v0 = valid_cnt; e0 = err_cnt;
    apply_stimulus(8'hA5, 1, 1, 0, 1, 1, 100000, 0);
    repeat (5) @(posedge clk); #1;
    check_output("par_err", err_cnt - e0, 1);
    check_output("par_valid", valid_cnt - v0, 0);
    check_output("par_data", rx_data, 8'hA5);

    // Second stop bit low.
    v0 = valid_cnt; e0 = err_cnt;
    apply_stimulus(8'h3C, 0, 0, 1, 1, 0, 100000, 0);
    repeat (5) @(posedge clk); #1;
    check_output("stop_err", err_cnt - e0, 1);
    check_output("stop_valid", valid_cnt - v0, 0);
    check_output("stop_data", rx_data, 8'h3C);

    // Short glitch while idle.
    v0 = valid_cnt; e0 = err_cnt; busy_cycles = 0; d0 = rx_data;
    stopbit = 1'b0;
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 20);
    check_output("glitch_busy_seen", (busy_cycles > 0 && busy_cycles <= 10), 1);
    check_output("glitch_busy_end", busy, 0);
    check_output("glitch_pulses", (valid_cnt - v0) + (err_cnt - e0), 0);
    check_output("glitch_data", rx_data, d0);

    // Receiver disabled ignores the line.
    baudrate = 17'd0; busy_cycles = 0;
    drive_bit(1'b0, 30);
    drive_bit(1'b1, 10);
    check_output("disabled_busy", busy_cycles, 0);

    // Back-to-back frames with no idle gap.
    pulse_data.delete(); pulse_time.delete();
    v0 = valid_cnt; e0 = err_cnt;
    apply_stimulus(8'h00, 0, 0, 0, 1, 1, 100000, 0);
    apply_stimulus(8'hFF, 0, 0, 0, 1, 1, 100000, 0);
    repeat (5) @(posedge clk); #1;
    check_output("b2b_valid", valid_cnt - v0, 2);
    check_output("b2b_err", err_cnt - e0, 0);
    if (pulse_data.size() == 2) begin
      check_output("b2b_data0", pulse_data[0], 8'h00);
      check_output("b2b_data1", pulse_data[1], 8'hFF);
      check_output("b2b_gap", (pulse_time[1] - pulse_time[0] >= 95 &&
                               pulse_time[1] - pulse_time[0] <= 105), 1);
    end else begin
      check_output("b2b_pulse_count", pulse_data.size(), 2);
    end

    // Reset during data bit 4.
    baudrate = 17'd100000; parity_en = 1'b0; stopbit = 1'b0;
    drive_bit(1'b0, 10);
    for (int i = 0; i < 4; i++) drive_bit(r_data[0] ^ r_data[0] ^ (8'h3C >> i) & 1'b1, 10);
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    check_output("midrst_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check_output("midrst_busy", busy, 0);
    check_output("midrst_data", rx_data, 0);
    check_output("midrst_valid", rx_valid, 0);
    check_output("midrst_err", rx_err, 0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    v0 = valid_cnt; e0 = err_cnt;
    apply_stimulus(8'h3C, 0, 0, 0, 1, 1, 100000, 0);
    repeat (5) @(posedge clk); #1;
    check_output("postrst_valid", valid_cnt - v0, 1);
    check_output("postrst_err", err_cnt - e0, 0);
    check_output("postrst_data", rx_data, 8'h3C);

    // Randomized frames against the frame-level model.
    for (int n = 0; n < 30; n++) begin
      r_data = 8'($urandom);
      r_par  = 1'($urandom);
      r_two  = 1'($urandom);
      r_pbit = (^r_data) ^ ($urandom_range(0, 3) == 0);
      r_s1   = ($urandom_range(0, 5) != 0);
      r_s2   = ($urandom_range(0, 5) != 0);
      r_sel  = $urandom_range(0, 3);
      r_baud = baud_set[r_sel];
      r_gap  = $urandom_range(3, 20);
      r_err  = (r_par && (r_pbit != (^r_data))) || !r_s1 || (r_two && !r_s2);
      v0 = valid_cnt; e0 = err_cnt;
      apply_stimulus(r_data, r_par, r_pbit, r_two, r_s1, r_s2, r_baud, 1'($urandom));
      repeat (r_gap) @(posedge clk);
      #1;
      check_output("rand_valid", valid_cnt - v0, r_err ? 0 : 1);
      check_output("rand_err", err_cnt - e0, r_err ? 1 : 0);
      check_output("rand_data", rx_data, r_data);
    end

    check_output("data_change_outside_pulse", viol_cnt, 0);
    check_output("end_busy", busy, 0);

    $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Bit-level UART receive core that sits directly upstream of the UART RX system-bus controller. It synchronizes the raw `rx_i` line, detects start bits, and samples each bit at mid-period using a fractional baud accumulator, so no divider is needed. It delivers one byte per frame with a one-cycle valid or error pulse. Baud rate, parity enable and stop-bit count come from the controller's configuration registers.

## Interface
- `CLK_FREQ`, default 10_000_000: `clk_i` frequency in Hz; the accumulator modulus.
- `clk_i` in 1: system clock; all logic on its rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `rx_i` in 1: serial line, idle high, asynchronous to `clk_i`.
- `baudrate_i` in 17: bit rate in bit/s; legal range 1..CLK_FREQ/8; 0 = receiver disabled.
- `parity_en_i` in 1: 1 = one even-parity bit after the data bits.
- `stopbit_i` in 1: 0 = one stop bit, 1 = two stop bits.
- `busy_o` out 1: high whenever the FSM is not IDLE.
- `rx_data_o` out 8: last received byte, held until the next frame completes.
- `rx_valid_o` out 1: one-cycle pulse when a frame completes without error.
- `rx_err_o` out 1: one-cycle pulse when a frame completes with a parity or stop-bit error.

## Operation
- Input path:
  - `rx_i` passes through a 2-flop synchronizer; both flops reset to 1.
  - A third flop holds the previous synchronized value for edge detection.
- Bit timing:
  - The accumulator `acc` is `$clog2(2*CLK_FREQ)` bits wide.
  - Each active cycle: if `acc + baud` is at least CLK_FREQ, then `acc` becomes `acc + baud - CLK_FREQ` and a `tick` fires; otherwise `acc` becomes `acc + baud`.
  - At most one tick occurs per cycle.
- Config latch: `baudrate_i`, `parity_en_i` and `stopbit_i` are captured at start detection. Changes mid-frame are ignored until the next frame.
- FSM transitions:
  - IDLE: on a synchronized falling edge with `baudrate_i` != 0, latch config, load `acc` = CLK_FREQ/2, go to START. With `baudrate_i` == 0, stay in IDLE and ignore the line.
  - START: on tick, if the sample is 0 go to DATA with bit count 0; if the sample is 1 it is a false start, so return to IDLE with no pulse.
  - DATA: on each tick, shift the sample in LSB-first. After 8 samples, go to PARITY if parity is enabled, else STOP.
  - PARITY: on tick, flag a parity error if the XOR of the sample and the 8 data bits is not 0. Go to STOP.
  - STOP: on each tick, sample the bit and flag a frame error if it is 0. After 1 or 2 samples (per latched `stopbit`), go to IDLE.
- Frame completion:
  - On entering IDLE from STOP, `rx_data_o` is loaded with the shift register in every case.
  - Exactly one of `rx_valid_o` or `rx_err_o` pulses, per the error flags; the flags then clear.
- Back-to-back frames: the FSM leaves STOP at the middle of the last stop bit, so an immediately following start edge is detected.
- Reset: asynchronous, at any time including mid-frame.
  - FSM goes to IDLE; `acc`, shift register and error flags go to 0.
  - Synchronizer goes to 1.
  - Outputs: `busy_o` = 0, `rx_data_o` = 0, `rx_valid_o` = 0, `rx_err_o` = 0.

## Timing
- Input latency: 2 cycles from an `rx_i` change to the synchronized value, plus 1 cycle to edge detection.
- Bit period: average CLK_FREQ/baud cycles; tick jitter is at most 1 cycle, with no cumulative drift.
- First tick arrives about (CLK_FREQ/2)/baud cycles after start detection, i.e. at mid-start-bit.
- `busy_o` timing:
  - Rises in the cycle after the falling edge is detected (FSM in START).
  - Falls in the same cycle that `rx_valid_o` or `rx_err_o` is high, or one cycle after a false-start tick.
- `rx_data_o` changes only in the cycle where `rx_valid_o` or `rx_err_o` is high.
- Frame length: 1 + 8 + parity + stop bits; pulses occur at mid-last-stop-bit.

## Test plan
All scenarios use CLK_FREQ = 1_000_000 and baud = 100_000 (10 cycles/bit).
- **Clean frame:** send 0xA5 with parity on (parity bit 0) and 1 stop bit → one `rx_valid_o` pulse, `rx_data_o` = 0xA5, `rx_err_o` never high, `busy_o` high for about 105 cycles.
- **Parity error:** send 0xA5 with parity bit 1 → `rx_err_o` pulses, `rx_data_o` = 0xA5, no `rx_valid_o`.
- **Stop-bit error:** with `stopbit_i` = 1 and parity off, send 0x3C with the second stop bit driven 0 → `rx_err_o` pulse, no valid pulse.
- **Glitch:** drive `rx_i` low for 3 cycles while idle → `busy_o` pulses, then returns to 0 after the mid-start tick; no valid or error pulse; `rx_data_o` unchanged.
- **Back-to-back:** send 0x00 then 0xFF with no idle gap, parity off, 1 stop bit → two `rx_valid_o` pulses about 100 cycles apart, with data 0x00 then 0xFF.
- **Reset mid-frame:** assert `rst_ni` = 0 during data bit 4 → all outputs 0 in the same cycle (asynchronous). After release with the line held high for 20 cycles, send 0x3C → `rx_valid_o` pulses with data 0x3C.
